// File: rtl/sdc_regs_pkg.sv
// Shared definitions for the SD command sequencer.
// Holds the sdc_controller register map, EVT status bit positions, the
// response-type and error-code enums, the sequencer FSM state enum and a
// helper that builds the CMD flag byte.
package sdc_regs_pkg;

    // sdc_controller register addresses (7-bit bus)
    localparam logic [6:0] REG_ARG0      = 7'h00;  // ARG bytes 0x00..0x03, LSB first
    localparam logic [6:0] REG_CMD_FLAGS = 7'h04;
    localparam logic [6:0] REG_CMD_INDEX = 7'h05;  // writing this byte launches the command
    localparam logic [6:0] REG_RSP0      = 7'h08;  // RSP bytes 0x08..0x0B, LSB first
    localparam logic [6:0] REG_EVT       = 7'h30;  // command event status, write 0x00 clears

    // EVT status bits
    localparam int EVT_CMPL_BIT = 0;
    localparam int EVT_ERR_BIT  = 1;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_R48  = 2'd1,
        RSP_R136 = 2'd2,   // only the low 32 bits are read back
        RSP_R48B = 2'd3
    } rsp_type_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_CTRL    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ARG    = 3'd1,
        ST_WR_CMD    = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_POLL_RD   = 3'd4,
        ST_RD_RSP    = 3'd5,
        ST_CLR       = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // CMD flag byte: {3'b0, idx_chk, crc_chk, 1'b0, rsp_type}. Index and CRC
    // checks are only meaningful when a response is expected.
    function automatic logic [7:0] cmd_flags(input rsp_type_e t);
        logic chk;
        chk = (t != RSP_NONE);
        return {3'b000, chk, chk, 1'b0, t};
    endfunction

endpackage

// File: rtl/sdc_poll_timer.sv
// Poll pacing and poll limit for the SD command sequencer.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   clear_i          restart the poll count (asserted when a request is accepted)
//   gap_run_i        high while the sequencer idles between polls
//   poll_tick_i      one pulse per status poll that found neither complete nor error
//   gap_done_o       last idle cycle of the inter-poll gap
//   poll_expired_o   the poll being evaluated is the last one allowed
module sdc_poll_timer #(
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic gap_run_i,
    input  logic poll_tick_i,
    output logic gap_done_o,
    output logic poll_expired_o
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [10:0]   POLL_LAST = 11'(POLL_TIMEOUT - 1);

    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [10:0]   poll_cnt_q, poll_cnt_d;

    always_comb begin
        // The gap counter sits at zero whenever the sequencer is not waiting,
        // so every wait period starts counting from the beginning.
        gap_cnt_d = '0;
        if (gap_run_i) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end

        poll_cnt_d = poll_cnt_q;
        if (clear_i) begin
            poll_cnt_d = '0;
        end else if (poll_tick_i) begin
            poll_cnt_d = poll_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign gap_done_o     = gap_run_i && (gap_cnt_q == GAP_LAST);
    // The count holds polls already failed; when it equals TIMEOUT-1 the
    // current poll is the TIMEOUT-th one.
    assign poll_expired_o = (poll_cnt_q == POLL_LAST);

endmodule

// File: rtl/sdc_cmd_sequencer.sv
// Issues one SD command at a time over sdc_controller's 7-bit address /
// 8-bit data register bus: writes argument and command bytes, polls EVT
// until complete, error or timeout, reads the 32-bit response, clears EVT.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake (see below)
//   req_index, req_arg,      command index, argument and response type,
//   req_rsp_type             captured only at accept
//   bus_addr, bus_we,        register bus master outputs, one byte per cycle
//   bus_wdata
//   bus_rdata                read data, valid the cycle after bus_addr
//   done                     one-cycle pulse at the end of each command
//   rsp, err                 result of the last finished command, held
//   dbg_state                current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a request held
// valid while a command is running waits; it is taken on the first IDLE
// cycle, which is the cycle after done.
module sdc_cmd_sequencer
    import sdc_regs_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_index,
    input  logic [31:0] req_arg,
    input  logic [1:0]  req_rsp_type,
    output logic [6:0]  bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        done,
    output logic [31:0] rsp,
    output logic [1:0]  err,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;      // byte / phase index within a state
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    rsp_type_e   rtype_q, rtype_d;
    err_e        err_cur_q, err_cur_d; // outcome of the command in flight
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rsp_q, rsp_d;
    err_e        err_q, err_d;
    logic        done_q, done_d;
    logic        bus_we_q, bus_we_d;
    logic [6:0]  bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;

    logic        accept;
    logic        poll_tick;
    logic        gap_done;
    logic        poll_expired;
    logic [1:0]  rsp_sel;

    sdc_poll_timer #(
        .POLL_TIMEOUT (POLL_TIMEOUT),
        .POLL_GAP     (POLL_GAP)
    ) u_poll_timer (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (accept),
        .gap_run_i      (state_q == ST_POLL_WAIT),
        .poll_tick_i    (poll_tick),
        .gap_done_o     (gap_done),
        .poll_expired_o (poll_expired)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        rtype_d   = rtype_q;
        err_cur_d = err_cur_q;
        shadow_d  = shadow_q;
        rsp_d     = rsp_q;
        err_d     = err_q;
        accept    = 1'b0;
        poll_tick = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    idx_d     = req_index;
                    arg_d     = req_arg;
                    rtype_d   = rsp_type_e'(req_rsp_type);
                    err_cur_d = ERR_OK;
                    step_d    = 3'd0;
                    state_d   = ST_WR_ARG;
                end
            end
            ST_WR_ARG: begin
                if (step_q == 3'd3) begin
                    step_d  = 3'd0;
                    state_d = ST_WR_CMD;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_WR_CMD: begin
                if (step_q == 3'd1) begin
                    step_d  = 3'd0;
                    state_d = (POLL_GAP > 0) ? ST_POLL_WAIT : ST_POLL_RD;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_POLL_WAIT: begin
                if (gap_done) begin
                    step_d  = 3'd0;
                    state_d = ST_POLL_RD;
                end
            end
            ST_POLL_RD: begin
                // Phase 0 presents the EVT address, phase 1 sees its data.
                if (step_q == 3'd0) begin
                    step_d = 3'd1;
                end else begin
                    step_d = 3'd0;
                    if (bus_rdata[EVT_ERR_BIT]) begin
                        err_cur_d = ERR_CTRL;
                        state_d   = ST_CLR;
                    end else if (bus_rdata[EVT_CMPL_BIT]) begin
                        state_d = (rtype_q == RSP_NONE) ? ST_CLR : ST_RD_RSP;
                    end else begin
                        poll_tick = 1'b1;
                        if (poll_expired) begin
                            err_cur_d = ERR_TIMEOUT;
                            state_d   = ST_CLR;
                        end else begin
                            state_d = (POLL_GAP > 0) ? ST_POLL_WAIT : ST_POLL_RD;
                        end
                    end
                end
            end
            ST_RD_RSP: begin
                // Addresses go out on steps 0..3; with one cycle of read
                // latency the bytes arrive on steps 1..4.
                if (step_q != 3'd0) begin
                    shadow_d = {bus_rdata, shadow_q[31:8]};
                end
                if (step_q == 3'd4) begin
                    step_d  = 3'd0;
                    state_d = ST_CLR;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_CLR: begin
                state_d = ST_DONE;
                err_d   = err_cur_q;
                // A failed or response-less command leaves the previous
                // response visible.
                if (err_cur_q == ERR_OK && rtype_q != RSP_NONE) begin
                    rsp_d = shadow_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_sel = (step_d >= 3'd3) ? 2'd3 : step_d[1:0];

    // Bus outputs are registered from the next state so they line up with
    // the state register and stay glitch-free.
    always_comb begin
        bus_we_d    = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = (state_d == ST_DONE);

        case (state_d)
            ST_WR_ARG: begin
                bus_we_d    = 1'b1;
                bus_addr_d  = REG_ARG0 + {4'b0000, step_d};
                bus_wdata_d = arg_d[{step_d[1:0], 3'b000} +: 8];
            end
            ST_WR_CMD: begin
                bus_we_d = 1'b1;
                if (step_d == 3'd0) begin
                    bus_addr_d  = REG_CMD_FLAGS;
                    bus_wdata_d = cmd_flags(rtype_d);
                end else begin
                    bus_addr_d  = REG_CMD_INDEX;
                    bus_wdata_d = {2'b00, idx_d};
                end
            end
            ST_POLL_RD: begin
                bus_addr_d = REG_EVT;
            end
            ST_RD_RSP: begin
                bus_addr_d = REG_RSP0 + {5'b00000, rsp_sel};
            end
            ST_CLR: begin
                bus_we_d    = 1'b1;
                bus_addr_d  = REG_EVT;
                bus_wdata_d = 8'h00;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 3'd0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            rtype_q     <= RSP_NONE;
            err_cur_q   <= ERR_OK;
            shadow_q    <= 32'd0;
            rsp_q       <= 32'd0;
            err_q       <= ERR_OK;
            done_q      <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 7'd0;
            bus_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            rtype_q     <= rtype_d;
            err_cur_q   <= err_cur_d;
            shadow_q    <= shadow_d;
            rsp_q       <= rsp_d;
            err_q       <= err_d;
            done_q      <= done_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_wdata = bus_wdata_q;
    assign done      = done_q;
    assign rsp       = rsp_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
module tb_sdc_cmd_sequencer;

    localparam int GAP = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_index = 6'd0;
    logic [31:0] req_arg = 32'd0;
    logic [1:0]  req_rsp_type = 2'd0;
    logic [6:0]  bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'd0;
    logic        done;
    logic [31:0] rsp;
    logic [1:0]  err;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    sdc_cmd_sequencer #(
        .POLL_TIMEOUT (TMO),
        .POLL_GAP     (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_arg      (req_arg),
        .req_rsp_type (req_rsp_type),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .done         (done),
        .rsp          (rsp),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // ---------------- controller model + monitor ----------------
    // EVT reads return evt_val once evt_delay cycles have passed since the
    // index write; with GAP=2, poll n samples at delay 2 + 4*(n-1).
    logic [31:0] rsp_val   = 32'd0;
    logic [7:0]  evt_val   = 8'h01;
    int          evt_delay = 2;
    logic        armed     = 1'b0;
    int          since     = 0;
    int          cyc       = 0;
    int          acc_cyc   = 0;
    int          done_cyc  = 0;
    int          done_cnt  = 0;
    int          rsp_reads = 0;
    logic [14:0] wr_log[$];
    logic [14:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cyc <= cyc;
        if (done) begin
            done_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (bus_we) wr_log.push_back({bus_addr, bus_wdata});
        if (!bus_we && bus_addr >= 7'h08 && bus_addr <= 7'h0B) rsp_reads <= rsp_reads + 1;
        if (rst) begin
            armed <= 1'b0;
        end else if (bus_we && bus_addr == 7'h05) begin
            armed <= 1'b1;
            since <= 0;
        end else if (bus_we && bus_addr == 7'h30) begin
            armed <= 1'b0;
        end else if (armed) begin
            since <= since + 1;
        end
        if (bus_addr == 7'h30)
            bus_rdata <= (armed && since >= evt_delay) ? evt_val : 8'h00;
        else if (bus_addr >= 7'h08 && bus_addr <= 7'h0B)
            bus_rdata <= rsp_val[{bus_addr[1:0], 3'b000} +: 8];
        else
            bus_rdata <= 8'h00;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected write sequence of one command: 4 ARG bytes, flags, index, EVT clear.
    task automatic exp_cmd(input logic [31:0] arg, input logic [7:0] flags, input logic [7:0] idxb);
        exp_q.push_back({7'h00, arg[7:0]});
        exp_q.push_back({7'h01, arg[15:8]});
        exp_q.push_back({7'h02, arg[23:16]});
        exp_q.push_back({7'h03, arg[31:24]});
        exp_q.push_back({7'h04, flags});
        exp_q.push_back({7'h05, idxb});
        exp_q.push_back({7'h30, 8'h00});
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check_eq({tag, "_nwr"}, wr_log.size(), exp_q.size());
        n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_wr%0d", tag, i), {17'd0, wr_log[i]}, {17'd0, exp_q[i]});
        end
        wr_log.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        int n;
        @(negedge clk);
        req_index    = idx;
        req_arg      = arg;
        req_rsp_type = rt;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_rsp,
                             input logic [1:0] exp_err, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_latency"}, cyc - acc_cyc, exp_lat);
        check_eq({tag, "_rsp"}, rsp, exp_rsp);
        check_eq({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
        check_eq({tag, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rr;
        int dc;
        int n;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_we", {31'd0, bus_we}, 32'd0);
        check_eq("rst_addr", {25'd0, bus_addr}, 32'd0);
        check_eq("rst_wdata", {24'd0, bus_wdata}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_rsp", rsp, 32'd0);
        check_eq("rst_err", {30'd0, err}, 32'd0);
        check_eq("rst_state", {29'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: CMD17, complete on poll 2
        rsp_val = 32'h0000_0900; evt_val = 8'h01; evt_delay = 6;
        exp_cmd(32'h0000_1200, 8'h19, 8'h11);
        send(6'd17, 32'h0000_1200, 2'd1);
        wait_done("s1", 32'h0000_0900, 2'd0, 21);
        compare_writes("s1");

        // 1b: R136, all response bytes distinct, complete on poll 1
        rr = rsp_reads;
        rsp_val = 32'hA1B2_C3D4; evt_delay = 2;
        exp_cmd(32'hDEAD_BEEF, 8'h1A, 8'h02);
        send(6'd2, 32'hDEAD_BEEF, 2'd2);
        wait_done("s1b", 32'hA1B2_C3D4, 2'd0, 17);
        compare_writes("s1b");
        check_eq("s1b_rsp_reads", rsp_reads - rr, 5);

        // 2: CMD0, no response
        rr = rsp_reads;
        rsp_val = 32'h5555_5555;
        exp_cmd(32'h0, 8'h00, 8'h00);
        send(6'd0, 32'h0, 2'd0);
        wait_done("s2", 32'hA1B2_C3D4, 2'd0, 12);
        compare_writes("s2");
        check_eq("s2_rsp_reads", rsp_reads - rr, 0);

        // 3: EVT = 0x03, error wins over complete
        rr = rsp_reads;
        evt_val = 8'h03; rsp_val = 32'hFFFF_0000;
        exp_cmd(32'h1234_5678, 8'h19, 8'h37);
        send(6'd55, 32'h1234_5678, 2'd1);
        wait_done("s3", 32'hA1B2_C3D4, 2'd1, 12);
        compare_writes("s3");
        check_eq("s3_rsp_reads", rsp_reads - rr, 0);

        // 4: EVT never set, timeout after 8 polls
        rr = rsp_reads;
        evt_val = 8'h01; evt_delay = 100000;
        exp_cmd(32'h0000_0001, 8'h19, 8'h0D);
        send(6'd13, 32'h0000_0001, 2'd1);
        wait_done("s4", 32'hA1B2_C3D4, 2'd2, 40);
        compare_writes("s4");
        check_eq("s4_rsp_reads", rsp_reads - rr, 0);

        // 5: req_valid held through two commands
        rsp_val = 32'h1122_3344; evt_delay = 2;
        exp_cmd(32'h0000_0200, 8'h19, 8'h18);
        exp_cmd(32'h0000_0000, 8'h1B, 8'h0C);
        @(negedge clk);
        req_index = 6'd24; req_arg = 32'h0000_0200; req_rsp_type = 2'd1; req_valid = 1'b1;
        @(negedge clk);
        req_index = 6'd12; req_arg = 32'h0000_0000; req_rsp_type = 2'd3;
        check_eq("s5_ready_busy", {31'd0, req_ready}, 32'd0);
        wait_done("s5a", 32'h1122_3344, 2'd0, 17);
        check_eq("s5_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("s5_accept_after_done", acc_cyc - done_cyc, 1);
        wait_done("s5b", 32'h1122_3344, 2'd0, 17);
        compare_writes("s5");

        // 6: reset during WR_CMD
        dc = done_cnt;
        rsp_val = 32'h0BAD_F00D;
        @(negedge clk);
        req_index = 6'd9; req_arg = 32'hCAFE_F00D; req_rsp_type = 2'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(bus_we && bus_addr == 7'h04) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("s6_in_wr_cmd", {25'd0, bus_addr}, 32'h04);
        rst = 1'b1;
        @(negedge clk);
        check_eq("s6_we", {31'd0, bus_we}, 32'd0);
        check_eq("s6_ready", {31'd0, req_ready}, 32'd1);
        check_eq("s6_addr", {25'd0, bus_addr}, 32'd0);
        check_eq("s6_rsp", rsp, 32'd0);
        check_eq("s6_err", {30'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("s6_no_done", done_cnt - dc, 0);
        wr_log.delete();
        exp_cmd(32'h0000_1200, 8'h19, 8'h11);
        send(6'd17, 32'h0000_1200, 2'd1);
        wait_done("s6r", 32'h0BAD_F00D, 2'd0, 17);
        compare_writes("s6r");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
